mspi_flash_writer: RTL
======================

// Module: mspi_flash_writer
// PURPOSE
//  SPI NOR flash writer (mode 0, single-bit). Performs page program (0x02) or 4 KB sector erase (0x20).
//  Each operation is WREN (0x06), then the command, then status polling (0x05) until WIP=0.
//  Write-side counterpart of the video flash reader; loads the image/assets that gen_video later streams.
//  Sits on the pixel clock domain; shares flash pins with the reader through an external mux (not in this block).
// PARAMETERS
//  CLK_DIV    2        clk cycles per SCK half-period (>=1); SCK = clk/(2*CLK_DIV)
//  CS_GAP     4        min clk cycles CS_n held high between transactions
//  POLL_MAX   20'hFFFFF max status reads before timeout
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  start      in   1   1-cycle pulse; accepted only when busy=0
//  op         in   1   0=page program, 1=sector erase; sampled with start
//  addr       in   24  flash byte address; sampled with start
//  len        in   9   program byte count 1..256; sampled with start; ignored for erase
//  in_data    in   8   program data byte
//  in_valid   in   1   in_data valid
//  in_ready   out  1   byte accepted when in_valid&&in_ready
//  busy       out  1   operation in progress
//  done       out  1   1-cycle pulse at operation end (success or error)
//  err        out  1   held from done until next accepted start: 1=rejected or timeout
//  spi_cs_n   out  1   flash chip select, active-low
//  spi_sck    out  1   flash clock, idles low
//  spi_mosi   out  1   flash data in
//  spi_miso   in   1   flash data out
// BEHAVIOUR
//  Reset values: in_ready=0, busy=0, done=0, err=0, spi_cs_n=1, spi_sck=0, spi_mosi=0; FSM in IDLE.
//  Reset mid-operation aborts immediately; CS_n rises asynchronously. The flash sees an aborted command.
//  SPI mode 0: MOSI updates CLK_DIV cycles before each SCK rise, MSB first. MISO is sampled on the cycle SCK rises.
//  start with busy=1 is ignored.
//  Program start with len==0, len>256, or addr[7:0]+len>256 (page wrap):
//   no SPI activity; done and err=1 are asserted 1 cycle after start.
//  FSM states:
//   IDLE -> WREN (CS low, 8 SCK of 0x06) -> GAP
//   -> CMD (0x02 or 0x20) -> ADDR (addr[23:0], MSB first)
//   -> DATA (program only) -> GAP
//   -> POLL (0x05, then 8 SCK reading status) -> GAP -> CHECK
//   -> POLL if status[0]=1, else FIN -> IDLE
//  GAP holds CS_n=1, SCK=0 for CS_GAP cycles.
//  CMD, ADDR and DATA are one continuous CS-low frame.
//  DATA: in_ready asserts when the shifter needs the next byte, and stays high until the handshake.
//   If in_valid=0, SCK stops low and CS stays low (stall is legal in mode 0).
//   Exactly len bytes are consumed; in_ready=0 outside DATA.
//  Byte counter: 9 bits, counts down from len. Poll counter: 20 bits. Exceeding POLL_MAX reads -> FIN with err=1.
//  FIN: CS_n=1, done=1 for one cycle, busy falls in the same cycle. start is accepted again on the next cycle.
//  busy rises the cycle after an accepted start (also for rejected starts, for exactly 1 cycle).
// STRUCTURE
//  Package mspi_flash_pkg: opcode localparams (OP_WREN=8'h06, OP_PP=8'h02, OP_SE=8'h20, OP_RDSR=8'h05),
//   FSM state typedef enum, PAGE_BYTES=256.
//  Sub-module spi_byte_shifter: mode-0, one byte, full duplex.
//   Ports: load/tx_byte/rx_byte/byte_done/hold; owns SCK generation with CLK_DIV.
//  Top FSM sequences bytes, owns CS_n, the counters and the handshake.
// TESTING (flash behavioural model on SPI pins, CLK_DIV=2, CS_GAP=4)
//  1 Reset during DATA -> next cycle cs_n=1, sck=0, busy=0, in_ready=0, done=0; model sees <256 bytes.
//  2 Program addr=24'h012300, len=4, bytes A5 5A 00 FF, model WIP for 3 polls ->
//     model sees 06 | 02 01 23 00 A5 5A 00 FF | 05x4; one done, err=0.
//  3 Erase addr=24'h010000 -> frames 06 | 20 01 00 00 | polls; in_ready never asserts; err=0.
//  4 Program addr=24'h0000F0, len=17 -> done 1 cycle later, err=1, cs_n never falls.
//  5 in_valid low for 50 cycles mid-DATA -> sck held 0, cs_n held 0, byte stream intact.
//  6 Model WIP stuck at 1, POLL_MAX=8 -> 8 status reads, then done with err=1; start during busy ignored.

Source files
------------

// File: rtl/mspi_flash_pkg.sv
// Opcodes, page geometry and FSM encoding shared by the SPI NOR flash writer.
// Also holds the page-program argument check used when a start is accepted.
package mspi_flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam int PAGE_BYTES = 256;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_GAP,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_POLL,
        S_CHECK,
        S_FIN
    } state_t;

    // A program must stay inside one page, so the end offset may not pass it.
    function automatic logic pp_bad(input logic [7:0] lo, input logic [8:0] n);
        logic [9:0] end_ofs;
        end_ofs = {2'b00, lo} + {1'b0, n};
        return (n == 9'd0) || (n > 9'(PAGE_BYTES)) || (end_ofs > 10'(PAGE_BYTES));
    endfunction

endpackage

// File: rtl/mspi_flash_writer_spi_byte_shifter.sv
// Mode-0 single-byte full-duplex SPI shifter; owns SCK generation.
// MOSI leads each SCK rise by CLK_DIV cycles; MISO is captured as SCK rises.
module spi_byte_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       hold,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       sck,
    output logic       mosi
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic        active;
    logic [15:0] div_cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  tx_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_byte   <= '0;
            byte_done <= 1'b0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (!active) begin
                if (load) begin
                    active  <= 1'b1;
                    tx_sh   <= tx_byte[6:0];
                    mosi    <= tx_byte[7];
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
            end else if (!(hold && !sck)) begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt <= div_cnt + 16'd1;
                end else begin
                    div_cnt <= '0;
                    if (!sck) begin
                        sck     <= 1'b1;
                        rx_byte <= {rx_byte[6:0], miso};
                    end else begin
                        sck <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            active    <= 1'b0;
                            byte_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            mosi    <= tx_sh[6];
                            tx_sh   <= {tx_sh[5:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mspi_flash_writer.sv
// SPI NOR flash writer: WREN, page program or sector erase, then status polling.
// Sequences bytes through the shifter and owns CS_n, the counters and the data handshake.
module mspi_flash_writer
    import mspi_flash_pkg::*;
#(
    parameter int          CLK_DIV  = 2,
    parameter int          CS_GAP   = 4,
    parameter logic [19:0] POLL_MAX = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [23:0] addr,
    input  logic [8:0]  len,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    state_t      state;
    state_t      gap_next;
    logic        load;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic [15:0] gap_cnt;
    logic [23:0] addr_q;
    logic [1:0]  idx;
    logic [8:0]  byte_cnt;
    logic [19:0] poll_cnt;
    logic        poll_rd;
    logic        wip;
    logic        op_q;
    logic        unused_rx;

    // Only the WIP bit of the status register matters here.
    assign unused_rx = &{1'b0, rx_byte[7:1]};

    spi_byte_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .tx_byte  (tx_byte),
        .hold     (1'b0),
        .miso     (spi_miso),
        .rx_byte  (rx_byte),
        .byte_done(byte_done),
        .sck      (spi_sck),
        .mosi     (spi_mosi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gap_next <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            spi_cs_n <= 1'b1;
            load     <= 1'b0;
            tx_byte  <= '0;
            gap_cnt  <= '0;
            addr_q   <= '0;
            idx      <= '0;
            byte_cnt <= '0;
            poll_cnt <= '0;
            poll_rd  <= 1'b0;
            wip      <= 1'b0;
            op_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            load <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        addr_q   <= addr;
                        byte_cnt <= len;
                        poll_cnt <= '0;
                        busy     <= 1'b1;
                        if (!op && pp_bad(addr[7:0], len)) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            err      <= 1'b0;
                            spi_cs_n <= 1'b0;
                            load     <= 1'b1;
                            tx_byte  <= OP_WREN;
                            state    <= S_WREN;
                        end
                    end
                end
                S_WREN: begin
                    if (byte_done) begin
                        spi_cs_n <= 1'b1;
                        gap_cnt  <= '0;
                        gap_next <= S_CMD;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= gap_next;
                        poll_rd <= 1'b0;
                        tx_byte <= (gap_next == S_CMD) ? (op_q ? OP_SE : OP_PP) : OP_RDSR;
                        if (gap_next != S_CHECK) begin
                            spi_cs_n <= 1'b0;
                            load     <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                S_CMD: begin
                    if (byte_done) begin
                        load    <= 1'b1;
                        tx_byte <= addr_q[23:16];
                        addr_q  <= {addr_q[15:0], 8'h00};
                        idx     <= '0;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (byte_done) begin
                        if (idx != 2'd2) begin
                            load    <= 1'b1;
                            tx_byte <= addr_q[23:16];
                            addr_q  <= {addr_q[15:0], 8'h00};
                            idx     <= idx + 2'd1;
                        end else if (!op_q) begin
                            in_ready <= 1'b1;
                            state    <= S_DATA;
                        end else begin
                            spi_cs_n <= 1'b1;
                            gap_cnt  <= '0;
                            gap_next <= S_POLL;
                            state    <= S_GAP;
                        end
                    end
                end
                S_DATA: begin
                    // SCK simply stays low while the source has nothing to give.
                    if (in_ready && in_valid) begin
                        in_ready <= 1'b0;
                        load     <= 1'b1;
                        tx_byte  <= in_data;
                        byte_cnt <= byte_cnt - 9'd1;
                    end else if (byte_done) begin
                        if (byte_cnt == 9'd0) begin
                            spi_cs_n <= 1'b1;
                            gap_cnt  <= '0;
                            gap_next <= S_POLL;
                            state    <= S_GAP;
                        end else begin
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_POLL: begin
                    if (byte_done) begin
                        if (!poll_rd) begin
                            poll_rd <= 1'b1;
                            load    <= 1'b1;
                            tx_byte <= 8'h00;
                        end else begin
                            wip      <= rx_byte[0];
                            poll_cnt <= poll_cnt + 20'd1;
                            spi_cs_n <= 1'b1;
                            gap_cnt  <= '0;
                            gap_next <= S_CHECK;
                            state    <= S_GAP;
                        end
                    end
                end
                S_CHECK: begin
                    if (!wip || poll_cnt >= POLL_MAX) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        err   <= wip;
                        state <= S_FIN;
                    end else begin
                        spi_cs_n <= 1'b0;
                        load     <= 1'b1;
                        tx_byte  <= OP_RDSR;
                        poll_rd  <= 1'b0;
                        state    <= S_POLL;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
